// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, its requesters and the shared memory.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic                          rsp_err;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          busy;
  logic                          mem_wr_en;
  logic                          mem_rd_en;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_data_in;
  logic [DATA_WIDTH-1:0]         mem_data_out;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
           mem_wr_en, mem_rd_en, mem_addr, mem_data_in
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
           mem_wr_en, mem_rd_en, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bounded lock that sequences one access at a time
// onto a single-port synchronous memory and returns a one-hot response.
module mem_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int MAX_LOCK   = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int          IDX_W      = $clog2(NUM_REQ);
  localparam int          CNT_W      = $clog2(MAX_LOCK + 1);
  localparam int unsigned DEPTH_U    = DEPTH;
  localparam int unsigned MAX_LOCK_U = MAX_LOCK;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic                  lock_q, lock_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  any_valid;
  logic                  regrant;
  logic                  in_range;
  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      winner;

  assign in_range = 32'(addr_q) < DEPTH_U;

  // Scanning from the farthest candidate back to last+1 leaves the nearest
  // valid requester as the final assignment.
  always_comb begin
    any_valid = |bus.req_valid;
    regrant   = lock_q && bus.req_valid[last_q] && (32'(lock_cnt_q) < MAX_LOCK_U);
    winner    = last_q;
    cand      = last_q;
    if (!regrant) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
        if (bus.req_valid[cand]) winner = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    lock_d     = lock_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = ISSUE;
          last_d     = winner;
          lock_d     = bus.req_lock[winner];
          lock_cnt_d = regrant ? lock_cnt_q + CNT_W'(1) : '0;
          we_d       = bus.req_we[winner];
          addr_d     = bus.req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d    = bus.req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        end else if (lock_q && !bus.req_valid[last_q]) begin
          lock_cnt_d = '0;
        end
      end
      ISSUE: begin
        err_d = !in_range;
        if (!in_range) begin
          rdata_d = '0;
          state_d = RESP;
        end else if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rdata_d = bus.mem_data_out;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && any_valid && !rst) bus.req_ready[winner] = 1'b1;
    bus.busy        = (state_q != IDLE);
    bus.mem_wr_en   = (state_q == ISSUE) && in_range && we_q;
    bus.mem_rd_en   = (state_q == ISSUE) && in_range && !we_q;
    bus.mem_addr    = (state_q == ISSUE) ? addr_q  : '0;
    bus.mem_data_in = (state_q == ISSUE) ? wdata_q : '0;
    bus.rsp_valid   = '0;
    if (state_q == RESP) bus.rsp_valid[last_q] = 1'b1;
    bus.rsp_err     = (state_q == RESP) && err_q;
    bus.rsp_rdata   = rdata_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// model of the arbitration rules and a reference copy of the memory contents.
module tb_mem_port_arbiter;
  localparam int NUM_REQ    = 2;
  localparam int DATA_WIDTH = 10;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 8;
  localparam int MAX_LOCK   = 4;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  mem_port_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [DATA_WIDTH-1:0] init_word(input int i);
    if (i == 3) return 10'h155;
    return DATA_WIDTH'((i * 37 + 11) & 'h3FF);
  endfunction

  // Environment memory: synchronous single port, read data one cycle after mem_rd_en.
  logic [DATA_WIDTH-1:0] env_mem [16];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
      bus.mem_data_out <= '0;
    end else begin
      if (bus.mem_wr_en) env_mem[bus.mem_addr] <= bus.mem_data_in;
      if (bus.mem_rd_en) bus.mem_data_out <= env_mem[bus.mem_addr];
    end
  end

  // Reference model state.
  logic [DATA_WIDTH-1:0] ref_mem [16];
  int                    m_last;
  int                    m_cnt;
  bit                    m_lock;
  logic [DATA_WIDTH-1:0] m_rdata;

  // Pending requests, one slot per requester.
  bit                    p_valid [NUM_REQ];
  bit                    p_we    [NUM_REQ];
  bit                    p_lock  [NUM_REQ];
  logic [ADDR_WIDTH-1:0] p_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] p_wdata [NUM_REQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NUM_REQ; i++) if (p_valid[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = p_valid[i];
      bus.req_we[i]    = p_we[i];
      bus.req_lock[i]  = p_lock[i];
      bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = p_addr[i];
      bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = p_wdata[i];
    end
  endtask

  task automatic model_reset();
    m_last  = NUM_REQ - 1;
    m_cnt   = 0;
    m_lock  = 1'b0;
    m_rdata = '0;
  endtask

  // Grant rule: a locked holder keeps the port while valid and under MAX_LOCK
  // re-grants; otherwise the first valid requester after the last winner wins.
  task automatic model_pick(output int w);
    bit found = 1'b0;
    w = m_last;
    if (m_lock && p_valid[m_last] && m_cnt < MAX_LOCK) begin
      m_cnt++;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && p_valid[(m_last + k) % NUM_REQ]) begin
          w     = (m_last + k) % NUM_REQ;
          found = 1'b1;
        end
      end
      m_cnt = 0;
    end
    m_last = w;
    m_lock = p_lock[w];
  endtask

  task automatic model_idle();
    if (m_lock && !p_valid[m_last]) m_cnt = 0;
  endtask

  task automatic rand_update();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!p_valid[i]) begin
        if ($urandom_range(1, 0) == 1) begin
          p_valid[i] = 1'b1;
          p_we[i]    = 1'($urandom_range(1, 0));
          p_lock[i]  = ($urandom_range(3, 0) == 0);
          p_addr[i]  = ADDR_WIDTH'($urandom_range(9, 0));
          p_wdata[i] = DATA_WIDTH'($urandom);
        end
      end else if ($urandom_range(7, 0) == 0) begin
        p_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input bit we, input bit lock,
                         input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] wdata);
    p_valid[i] = 1'b1;
    p_we[i]    = we;
    p_lock[i]  = lock;
    p_addr[i]  = addr;
    p_wdata[i] = wdata;
  endtask

  // One full transaction; entered and left at posedge+1 of an IDLE cycle.
  task automatic do_txn(input bit rnd);
    int                    w;
    bit                    we;
    bit                    oor;
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    drive();
    #2;
    model_pick(w);
    we  = p_we[w];
    a   = p_addr[w];
    d   = p_wdata[w];
    oor = (int'(a) >= DEPTH);
    check("idle_busy", bus.busy, 0);
    check("grant", bus.req_ready, oh(w));
    tick();
    p_valid[w] = 1'b0;
    if (rnd) rand_update();
    drive();
    #2;
    check("issue_busy", bus.busy, 1);
    check("issue_ready", bus.req_ready, 0);
    check("issue_wr", bus.mem_wr_en, !oor && we);
    check("issue_rd", bus.mem_rd_en, !oor && !we);
    check("issue_rsp", bus.rsp_valid, 0);
    if (!oor) check("issue_addr", bus.mem_addr, a);
    if (!oor && we) check("issue_wdata", bus.mem_data_in, d);
    if (!oor && !we) begin
      tick();
      #2;
      check("cap_strobe", {bus.mem_wr_en, bus.mem_rd_en}, 0);
      check("cap_rsp", bus.rsp_valid, 0);
      check("cap_ready", bus.req_ready, 0);
    end
    tick();
    #2;
    if (oor)      m_rdata = '0;
    else if (!we) m_rdata = ref_mem[a];
    else          ref_mem[a] = d;
    check("rsp_valid", bus.rsp_valid, oh(w));
    check("rsp_err", bus.rsp_err, oor);
    check("rsp_rdata", bus.rsp_rdata, m_rdata);
    check("rsp_ready", bus.req_ready, 0);
    check("rsp_strobe", {bus.mem_wr_en, bus.mem_rd_en}, 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst      = 1'b1;
    mem_load = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      p_valid[i] = 1'b0; p_we[i] = 1'b0; p_lock[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    model_reset();
    drive();
    tick();
    tick();
    mem_load = 1'b0;

    // Reset state, with a pending request that must not be accepted yet.
    p_valid[0] = 1'b1;
    drive();
    #2;
    check("rst_ready", bus.req_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_strobes", {bus.mem_wr_en, bus.mem_rd_en}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_din", bus.mem_data_in, 0);
    p_valid[0] = 1'b0;
    drive();
    rst = 1'b0;
    tick();

    // Single read of address 3.
    set_req(0, 1'b0, 1'b0, 4'd3, '0);
    do_txn(1'b0);

    // Contention: both requesters keep reads pending.
    for (int n = 0; n < 4; n++) begin
      set_req(0, 1'b0, 1'b0, ADDR_WIDTH'($urandom_range(DEPTH - 1, 0)), '0);
      set_req(1, 1'b0, 1'b0, ADDR_WIDTH'($urandom_range(DEPTH - 1, 0)), '0);
      do_txn(1'b0);
    end
    p_valid[0] = 1'b0;
    p_valid[1] = 1'b0;

    // Write then read back through requester 1.
    set_req(1, 1'b1, 1'b0, 4'd7, 10'h2AA);
    do_txn(1'b0);
    set_req(1, 1'b0, 1'b0, 4'd7, '0);
    do_txn(1'b0);

    // Lock: requester 0 re-arms a locked write while requester 1 waits.
    set_req(1, 1'b0, 1'b0, 4'd2, '0);
    for (int n = 0; n < MAX_LOCK + 2; n++) begin
      set_req(0, 1'b1, 1'b1, ADDR_WIDTH'(n % DEPTH), DATA_WIDTH'($urandom));
      do_txn(1'b0);
    end
    p_valid[0] = 1'b0;
    p_lock[0]  = 1'b0;
    p_valid[1] = 1'b0;

    // Out of range read and write at address DEPTH.
    set_req(0, 1'b0, 1'b0, ADDR_WIDTH'(DEPTH), '0);
    do_txn(1'b0);
    set_req(1, 1'b1, 1'b0, ADDR_WIDTH'(DEPTH), 10'h3FF);
    do_txn(1'b0);

    // Reset during CAPTURE of a read.
    set_req(0, 1'b0, 1'b0, 4'd3, '0);
    do_txn(1'b0);
    set_req(0, 1'b0, 1'b0, 4'd5, '0);
    drive();
    #2;
    model_pick(w);
    check("abort_grant", bus.req_ready, oh(w));
    tick();
    p_valid[0] = 1'b0;
    drive();
    #2;
    check("abort_issue_rd", bus.mem_rd_en, 1);
    tick();
    rst = 1'b1;
    #2;
    check("abort_cap_busy", bus.busy, 1);
    tick();
    #2;
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_rdata", bus.rsp_rdata, 0);
    check("abort_err", bus.rsp_err, 0);
    check("abort_strobes", {bus.mem_wr_en, bus.mem_rd_en}, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_ready", bus.req_ready, 0);
    rst = 1'b0;
    model_reset();
    tick();
    #2;
    check("post_abort_rsp", bus.rsp_valid, 0);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd1, '0);
    set_req(1, 1'b0, 1'b0, 4'd4, '0);
    do_txn(1'b0);
    p_valid[0] = 1'b0;
    p_valid[1] = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      if (!any_pending()) rand_update();
      if (any_pending()) begin
        do_txn(1'b1);
      end else begin
        drive();
        #2;
        check("idle_busy_r", bus.busy, 0);
        check("idle_ready_r", bus.req_ready, 0);
        model_idle();
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
